// File: rtl/vector_logic_sequencer_pkg.sv
// Shared types for the vector logic sequencer.
//   logic_op_t  : the eight RVV logical operations (3-bit encoding)
//   sew_t       : selected element width, 8/16/32/64 bits
//   lmul_t      : register group size, 1/2/4/8 beats
//   vls_state_t : sequencer FSM states
package vector_logic_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_ANDN = 3'b100,   // vs2 & ~vs1
        OP_NOR  = 3'b101,
        OP_ORN  = 3'b110,   // vs2 | ~vs1
        OP_XNOR = 3'b111
    } logic_op_t;

    typedef enum logic [1:0] {
        SEW_8  = 2'b00,
        SEW_16 = 2'b01,
        SEW_32 = 2'b10,
        SEW_64 = 2'b11
    } sew_t;

    typedef enum logic [1:0] {
        LMUL_1 = 2'b00,
        LMUL_2 = 2'b01,
        LMUL_4 = 2'b10,
        LMUL_8 = 2'b11
    } lmul_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10
    } vls_state_t;

    // Index of the final beat of a group: (1 << lmul) - 1.
    function automatic logic [2:0] last_beat_of(input lmul_t lmul);
        case (lmul)
            LMUL_1:  return 3'd0;
            LMUL_2:  return 3'd1;
            LMUL_4:  return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/vector_logic_sequencer_element_enable_gen.sv
// Combinational per-bit write enable for one beat of a register group.
//   sew  : element width of the group
//   vl   : active element count
//   v0   : mask register, bit i governs global element i
//   vm   : 1 = unmasked
//   beat : beat index within the group
//   en   : VLEN-bit enable, each element's active flag replicated over its bits
module vector_element_enable_gen
    import vector_logic_sequencer_pkg::*;
#(
    parameter int VLEN = 64,
    parameter int VL_W = $clog2(VLEN) + 1
) (
    input  sew_t              sew,
    input  logic [VL_W-1:0]   vl,
    input  logic [VLEN-1:0]   v0,
    input  logic              vm,
    input  logic [2:0]        beat,
    output logic [VLEN-1:0]   en
);

    localparam int unsigned LOG2_VLEN = $clog2(VLEN);

    always_comb begin
        logic [VL_W-1:0] idx;
        int unsigned     sh;
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        en  = '0;
        idx = '0;
        sh  = 3 + int'(sew);   // log2 of element width in bits
        for (int unsigned j = 0; j < VLEN; j++) begin
            // Global element index = beat * elements_per_beat + element_in_beat.
            // It never exceeds VLEN-1 because the largest group (SEW=8, LMUL=8)
            // holds exactly VLEN elements.
            idx   = (VL_W'(beat) << (LOG2_VLEN - sh)) + VL_W'(j >> sh);
            en[j] = (idx < vl) && (vm || v0[idx[LOG2_VLEN-1:0]]);
        end
    end

endmodule

// File: rtl/vector_logic_sequencer.sv
// Pipelined RVV logical-operation sequencer. Accepts one command, then one
// operand beat per cycle for a group of 1/2/4/8 registers, and returns each
// result beat one cycle later with tail/mask-undisturbed merging.
//   clock, reset        : clock, asynchronous active-high reset
//   cmd_*               : command handshake and fields (op, vm, sew, lmul, vl, v0)
//   opd_valid/opd_ready : operand beat handshake (vs2, vs1, vd_old)
//   res_valid/res_ready : result beat handshake (vd, res_last, res_beat)
module vector_logic_sequencer
    import vector_logic_sequencer_pkg::*;
#(
    parameter int VLEN = 64,
    parameter int VL_W = $clog2(VLEN) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_vm,
    input  logic [1:0]        cmd_sew,
    input  logic [1:0]        cmd_lmul,
    input  logic [VL_W-1:0]   cmd_vl,
    input  logic [VLEN-1:0]   cmd_v0,
    input  logic              opd_valid,
    output logic              opd_ready,
    input  logic [VLEN-1:0]   vs2,
    input  logic [VLEN-1:0]   vs1,
    input  logic [VLEN-1:0]   vd_old,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [VLEN-1:0]   vd,
    output logic              res_last,
    output logic [2:0]        res_beat
);

    vls_state_t        state;
    logic_op_t         op_q;
    logic              vm_q;
    sew_t              sew_q;
    logic [VL_W-1:0]   vl_q;
    logic [VLEN-1:0]   v0_q;
    logic [2:0]        last_beat_q;
    logic [2:0]        beat_cnt;

    logic [VLEN-1:0]   en;
    logic [VLEN-1:0]   func;
    logic [VLEN-1:0]   merged;
    logic              opd_fire;
    logic              res_fire;

    assign cmd_ready = (state == IDLE);
    // The single result register may be refilled in the same cycle it drains.
    assign opd_ready = (state == BUSY) && (!res_valid || res_ready);
    assign opd_fire  = opd_valid && opd_ready;
    assign res_fire  = res_valid && res_ready;

    vector_element_enable_gen #(
        .VLEN (VLEN),
        .VL_W (VL_W)
    ) u_enable (
        .sew  (sew_q),
        .vl   (vl_q),
        .v0   (v0_q),
        .vm   (vm_q),
        .beat (beat_cnt),
        .en   (en)
    );

    always_comb begin
        case (op_q)
            OP_AND:  func = vs2 & vs1;
            OP_OR:   func = vs2 | vs1;
            OP_XOR:  func = vs2 ^ vs1;
            OP_NAND: func = ~(vs2 & vs1);
            OP_ANDN: func = vs2 & ~vs1;
            OP_NOR:  func = ~(vs2 | vs1);
            OP_ORN:  func = vs2 | ~vs1;
            default: func = ~(vs2 ^ vs1);
        endcase
    end

    // Inactive and tail elements keep the old destination contents.
    assign merged = (func & en) | (vd_old & ~en);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_AND;
            vm_q        <= 1'b0;
            sew_q       <= SEW_8;
            vl_q        <= '0;
            v0_q        <= '0;
            last_beat_q <= '0;
            beat_cnt    <= '0;
            res_valid   <= 1'b0;
            res_last    <= 1'b0;
            res_beat    <= '0;
            vd          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= logic_op_t'(cmd_op);
                        vm_q        <= cmd_vm;
                        sew_q       <= sew_t'(cmd_sew);
                        vl_q        <= cmd_vl;
                        v0_q        <= cmd_v0;
                        last_beat_q <= last_beat_of(lmul_t'(cmd_lmul));
                        beat_cnt    <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (opd_fire) begin
                        if (beat_cnt == last_beat_q) begin
                            state <= DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (res_fire && res_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Result register: a new beat takes priority over clearing,
            // which gives back-to-back beats with no bubble.
            if (opd_fire) begin
                res_valid <= 1'b1;
                vd        <= merged;
                res_beat  <= beat_cnt;
                res_last  <= (beat_cnt == last_beat_q);
            end else if (res_fire) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vector_logic_sequencer.sv
// Directed self-checking bench for vector_logic_sequencer (VLEN = 64).
module tb_vector_logic_sequencer;

    localparam int VLEN = 64;
    localparam int VL_W = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic              cmd_vm;
    logic [1:0]        cmd_sew;
    logic [1:0]        cmd_lmul;
    logic [VL_W-1:0]   cmd_vl;
    logic [VLEN-1:0]   cmd_v0;
    logic              opd_valid;
    logic              opd_ready;
    logic [VLEN-1:0]   vs2;
    logic [VLEN-1:0]   vs1;
    logic [VLEN-1:0]   vd_old;
    logic              res_valid;
    logic              res_ready;
    logic [VLEN-1:0]   vd;
    logic              res_last;
    logic [2:0]        res_beat;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] g_vs2 [8];
    logic [63:0] g_vs1 [8];
    logic [63:0] g_old [8];
    logic [63:0] g_exp [8];

    always #5 clock = ~clock;

    vector_logic_sequencer #(.VLEN(VLEN), .VL_W(VL_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_vm    (cmd_vm),
        .cmd_sew   (cmd_sew),
        .cmd_lmul  (cmd_lmul),
        .cmd_vl    (cmd_vl),
        .cmd_v0    (cmd_v0),
        .opd_valid (opd_valid),
        .opd_ready (opd_ready),
        .vs2       (vs2),
        .vs1       (vs1),
        .vd_old    (vd_old),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .vd        (vd),
        .res_last  (res_last),
        .res_beat  (res_beat)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one command, stream its beats, and check every result beat.
    task automatic run_group(input string tag, input logic [2:0] op, input logic vm,
                             input logic [1:0] sew, input logic [1:0] lmul,
                             input logic [6:0] vl, input logic [63:0] v0,
                             input bit toggle);
        int beats;
        beats = 1 << lmul;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_vm = vm; cmd_sew = sew; cmd_lmul = lmul;
        cmd_vl = vl; cmd_v0 = v0;
        #1 check({tag, " cmd_ready idle"}, 64'(cmd_ready), 64'd1);
        @(negedge clock);
        cmd_valid = 1'b0;
        fork
            begin : producer
                int b;
                int cyc;
                logic fire;
                b = 0; cyc = 0;
                while (b < beats && cyc < 100) begin
                    opd_valid = 1'b1;
                    vs2 = g_vs2[b]; vs1 = g_vs1[b]; vd_old = g_old[b];
                    #1 fire = opd_ready;
                    @(posedge clock);
                    if (fire) b++;
                    @(negedge clock);
                    cyc++;
                end
                opd_valid = 1'b0;
            end
            begin : consumer
                int r;
                int cyc;
                r = 0; cyc = 0;
                while (r < beats && cyc < 100) begin
                    res_ready = toggle ? cyc[0] : 1'b1;
                    #1;
                    if (res_valid) begin
                        check({tag, " vd"}, vd, g_exp[r]);
                        check({tag, " res_beat"}, 64'(res_beat), 64'(r));
                        check({tag, " res_last"}, 64'(res_last), 64'(r == beats - 1));
                        check({tag, " cmd_ready busy"}, 64'(cmd_ready), 64'd0);
                        if (!res_ready) check({tag, " opd_ready stall"}, 64'(opd_ready), 64'd0);
                    end
                    @(posedge clock);
                    if (res_valid && res_ready) r++;
                    @(negedge clock);
                    cyc++;
                end
                check({tag, " beats returned"}, 64'(r), 64'(beats));
                res_ready = 1'b1;
            end
        join
        #1;
        check({tag, " cmd_ready after"}, 64'(cmd_ready), 64'd1);
        check({tag, " res_valid after"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_vm = 0; cmd_sew = 0; cmd_lmul = 0;
        cmd_vl = 0; cmd_v0 = 0; opd_valid = 0; vs2 = 0; vs1 = 0; vd_old = 0;
        res_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("reset res_valid", 64'(res_valid), 64'd0);
        check("reset vd", vd, 64'd0);
        check("reset res_last", 64'(res_last), 64'd0);
        check("reset res_beat", 64'(res_beat), 64'd0);
        check("reset cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset opd_ready", 64'(opd_ready), 64'd0);
        reset = 1'b0;

        // AND, SEW=64, LMUL=1, vl=1
        g_vs2[0] = 64'hF0F0_F0F0_0F0F_0F0F; g_vs1[0] = 64'hFFFF_0000_FFFF_0000;
        g_old[0] = 64'h0;                   g_exp[0] = 64'hF0F0_0000_0F0F_0000;
        run_group("and64", 3'b000, 1'b1, 2'b11, 2'b00, 7'd1, 64'h0, 1'b0);

        // XNOR, SEW=8, LMUL=2, vl=10: beat 1 has only bytes 0,1 active
        for (int i = 0; i < 2; i++) begin
            g_vs2[i] = 64'h0; g_vs1[i] = 64'h0; g_old[i] = 64'hAAAA_AAAA_AAAA_AAAA;
        end
        g_exp[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        g_exp[1] = 64'hAAAA_AAAA_AAAA_FFFF;
        run_group("xnor8", 3'b111, 1'b1, 2'b00, 2'b01, 7'd10, 64'h0, 1'b0);

        // Masked OR, SEW=16, vl=4, v0=0101
        g_vs2[0] = 64'h1111_1111_1111_1111; g_vs1[0] = 64'h0; g_old[0] = 64'h0;
        g_exp[0] = 64'h0000_1111_0000_1111;
        run_group("or16m", 3'b001, 1'b0, 2'b01, 2'b00, 7'd4, 64'b0101, 1'b0);

        // NOR and ORN, SEW=32, full beat
        g_vs2[0] = 64'hFF00_FF00_FF00_FF00; g_vs1[0] = 64'h0F0F_0F0F_0F0F_0F0F;
        g_old[0] = 64'h5555_5555_5555_5555; g_exp[0] = 64'h00F0_00F0_00F0_00F0;
        run_group("nor32", 3'b101, 1'b1, 2'b10, 2'b00, 7'd2, 64'h0, 1'b0);
        g_exp[0] = 64'hFFF0_FFF0_FFF0_FFF0;
        run_group("orn32", 3'b110, 1'b1, 2'b10, 2'b00, 7'd2, 64'h0, 1'b0);

        // ANDN, SEW=32, LMUL=4, vl=5, masked by v0=11101101: active elems 0,2,3
        for (int i = 0; i < 4; i++) begin
            g_vs2[i] = 64'hFFFF_FFFF_FFFF_FFFF; g_vs1[i] = 64'h0F0F_0F0F_0F0F_0F0F;
            g_old[i] = 64'h1234_5678_9ABC_DEF0;
        end
        g_exp[0] = 64'h1234_5678_F0F0_F0F0;
        g_exp[1] = 64'hF0F0_F0F0_F0F0_F0F0;
        g_exp[2] = 64'h1234_5678_9ABC_DEF0;
        g_exp[3] = 64'h1234_5678_9ABC_DEF0;
        run_group("andn32", 3'b100, 1'b0, 2'b10, 2'b10, 7'd5, 64'b1110_1101, 1'b0);

        // XOR, SEW=8, LMUL=8, vl=64, res_ready toggling
        for (int i = 0; i < 8; i++) begin
            g_vs2[i] = 64'h0123_4567_89AB_CDE0 + 64'(i);
            g_vs1[i] = 64'hFFFF_FFFF_0000_0000;
            g_old[i] = 64'h0;
        end
        for (int i = 0; i < 8; i++) g_exp[i] = {32'hFEDC_BA98, 32'h89AB_CDE0 + 32'(i)};
        run_group("xor8x8", 3'b010, 1'b1, 2'b00, 2'b11, 7'd64, 64'h0, 1'b1);

        // vl=0, NAND: every beat returns vd_old
        g_vs2[0] = 64'h0; g_vs1[0] = 64'h0; g_old[0] = 64'hDEAD_BEEF_0000_1111;
        g_vs2[1] = 64'h0; g_vs1[1] = 64'h0; g_old[1] = 64'hCAFE_F00D_2222_3333;
        g_exp[0] = g_old[0]; g_exp[1] = g_old[1];
        run_group("nand_vl0", 3'b011, 1'b1, 2'b00, 2'b01, 7'd0, 64'h0, 1'b0);

        // Reset mid-group, after beat 2 of an LMUL=4 group
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_vm = 1'b1; cmd_sew = 2'b00;
        cmd_lmul = 2'b10; cmd_vl = 7'd64; cmd_v0 = 64'h0;
        @(negedge clock);
        cmd_valid = 1'b0;
        opd_valid = 1'b1; vs2 = 64'hFFFF_FFFF_FFFF_FFFF; vs1 = 64'h1; vd_old = 64'h0;
        res_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1 check("rst pre beat", 64'(res_beat), 64'd2);
        reset = 1'b1;
        #1;
        check("rst res_valid", 64'(res_valid), 64'd0);
        check("rst vd", vd, 64'd0);
        check("rst res_last", 64'(res_last), 64'd0);
        check("rst res_beat", 64'(res_beat), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("rst cmd_ready", 64'(cmd_ready), 64'd1);
        begin
            int seen;
            seen = 0;
            repeat (5) begin
                @(negedge clock);
                #1 if (res_valid) seen++;
            end
            check("rst no res_valid", 64'(seen), 64'd0);
        end
        opd_valid = 1'b0;

        // Recovery after reset
        g_vs2[0] = 64'hF0F0_F0F0_0F0F_0F0F; g_vs1[0] = 64'hFFFF_0000_FFFF_0000;
        g_old[0] = 64'h0;                   g_exp[0] = 64'hF0F0_0000_0F0F_0000;
        run_group("and64 again", 3'b000, 1'b1, 2'b11, 2'b00, 7'd1, 64'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_logic_sequencer.md
Name: vector_logic_sequencer

Overview:
- Parametrised, pipelined successor to the single-cycle vector logic unit.
- Executes all eight RVV logical operations on a register group of LMUL = 1/2/4/8 registers, one VLEN-bit beat per cycle.
- Applies SEW-granular vl tail handling and v0 masking. Inactive and tail elements stay undisturbed.
- Sits in the vector execution stage between the operand-read sequencer and the writeback port, using valid/ready handshakes on both sides.

Parameters:
- VLEN, 64, vector register width in bits; power of two, at least 64.
- VL_W, $clog2(VLEN)+1, width of vl; VLMAX = VLEN at SEW=8, LMUL=8.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command can be accepted
- cmd_op  in  3  logic_op_t: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 ANDN (vs2&~vs1), 101 NOR, 110 ORN (vs2|~vs1), 111 XNOR
- cmd_vm  in  1  1 = unmasked, 0 = masked by v0
- cmd_sew  in  2  00 = 8, 01 = 16, 10 = 32, 11 = 64
- cmd_lmul  in  2  00 = 1, 01 = 2, 10 = 4, 11 = 8 beats
- cmd_vl  in  VL_W  active element count
- cmd_v0  in  VLEN  mask register; bit i controls element i of the group
- opd_valid  in  1  operand beat present
- opd_ready  out  1  operand beat accepted
- vs2  in  VLEN  source 2 beat
- vs1  in  VLEN  source 1 beat
- vd_old  in  VLEN  current destination contents for this beat
- res_valid  out  1  result beat valid
- res_ready  in  1  writeback accepts the beat
- vd  out  VLEN  result beat
- res_last  out  1  final beat of the group
- res_beat  out  3  beat index within the group

Behaviour:
- Reset (asynchronous, any cycle including mid-group):
  - state = IDLE; res_valid, res_last, res_beat, vd = 0.
  - cmd_ready = 1, opd_ready = 0.
  - Latched command fields cleared. The in-flight group is discarded; no partial writeback.
- FSM:
  - IDLE: cmd_ready = 1. A cmd_valid && cmd_ready cycle latches op, vm, sew, vl, v0 and beats = 1<<lmul, clears beat_cnt, moves to BUSY.
  - BUSY: opd_ready = !res_valid || res_ready (one-stage pipeline with back-pressure). Each opd handshake registers a result next cycle: res_valid = 1, res_beat = beat_cnt, res_last = (beat_cnt == beats-1), then beat_cnt increments. The handshake on beat beats-1 moves to DRAIN.
  - DRAIN: opd_ready = 0. Once the last result is taken (res_valid && res_ready && res_last), return to IDLE; cmd_ready rises the following cycle.
- Latency: 1 cycle from operand handshake to res_valid. Throughput: 1 beat/cycle while res_ready = 1.
- res_valid holds, with vd stable, until res_ready.
- Element enables, per beat b with E = VLEN/SEW:
  - Element e in the beat has global index i = b*E + e.
  - active(i) = (i < vl) && (vm || v0[i]).
  - The per-bit enable replicates active(i) across that element's SEW bits.
  - vd = (f(vs2, vs1) & en) | (vd_old & ~en).
- Boundaries:
  - vl = 0: every beat returns vd_old unchanged; beat count is still honoured.
  - vl ≥ LMUL*E: no tail.
  - vl mid-beat: the split is exact at SEW granularity.
- Handshakes:
  - cmd_valid while not IDLE is ignored; cmd_ready = 0.
  - opd_valid in IDLE or DRAIN is not accepted.
  - Output fire and new operand fire in the same cycle both occur; the result register is overwritten with no bubble.
- beat_cnt is 3 bits and never wraps past beats-1.

Decomposition:
- Add to dragonfang_pkg:
  - logic_op_t enum (3-bit);
  - sew_t and lmul_t enums;
  - vls_state_t {IDLE, BUSY, DRAIN}.
- Add to execution_vectors_pkg: the logic_op_t constants.
- Sub-module vector_element_enable_gen (combinational): inputs sew, vl, v0, vm, beat index; output the VLEN-bit per-bit enable.
- Logical function f: a case on logic_op_t inside the top module.

Test Plan:
- Unmasked AND, SEW=64, LMUL=1, vl=1: vs2 = 0xF0F0_F0F0_0F0F_0F0F, vs1 = 0xFFFF_0000_FFFF_0000 -> one beat, vd = 0xF0F0_0000_0F0F_0000, res_last = 1, then cmd_ready = 1.
- XNOR, SEW=8, LMUL=2, vl=10, vm=1, vs2 = vs1 = 0, vd_old = 0xAA..AA -> beat 0 vd = 0xFFFF_FFFF_FFFF_FFFF; beat 1 vd = 0xAAAA_AAAA_AAAA_FFFF.
- Masked OR, SEW=16, LMUL=1, vl=4, v0 = 0b0101, vs2 = 0x1111_1111_1111_1111, vs1 = 0, vd_old = 0 -> vd = 0x0000_1111_0000_1111.
- LMUL=8 with res_ready toggling 1/0 each cycle -> exactly 8 beats, res_beat 0..7 in order, vd stable while stalled, opd_ready low while stalled.
- vl=0, NAND -> all beats equal vd_old.
- reset asserted after beat 2 of LMUL=4 -> outputs zero within the same cycle, state IDLE, cmd_ready = 1 after reset deasserts, no further res_valid.
